ctl_mc: RTL and testbench

Multi-cycle Beta control unit that extends the single-cycle combinational decoder.
- Adds multi-cycle MUL/DIV stalls with parameterised latency.
- Adds a memory ready/wait handshake.
- Adds illegal-opcode trap (ILLOP) generation.
- Adds N prioritised, sticky interrupt channels, taken only at instruction boundaries.
Sits between the instruction register and the datapath. Drives the ALU, register file, memory and PC muxes, plus a stall line that freezes the PC and IR.

---
 rtl/ctl_mc_pkg.sv | 77 +++++++
 rtl/ctl_decode.sv | 97 +++++++++
 rtl/ctl_mc.sv | 178 +++++++++++++++++
 tb/tb_ctl_mc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_mc_pkg.sv
// Shared definitions for the multi-cycle Beta control unit: opcodes, ALU
// function codes, PC/write-data mux selects, FSM states, decode classes and
// the control-word struct handed from the decoder to the FSM.
package ctl_mc_pkg;

  // Non-ALU opcodes
  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // ALU-class opcodes are 10_xxxx (register form) or 11_xxxx (constant form);
  // the low nibble selects the function. These two nibbles are multi-cycle.
  localparam logic [3:0] FN_MUL = 4'h2;
  localparam logic [3:0] FN_DIV = 4'h3;

  // ALU function codes (boolean ops carry their truth table in bits [3:0])
  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_MUL   = 6'b000010;
  localparam logic [5:0] ALU_DIV   = 6'b000011;
  localparam logic [5:0] ALU_CMPEQ = 6'b110011;
  localparam logic [5:0] ALU_CMPLT = 6'b110101;
  localparam logic [5:0] ALU_CMPLE = 6'b110111;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_XNOR  = 6'b011001;
  localparam logic [5:0] ALU_SHL   = 6'b100000;
  localparam logic [5:0] ALU_SHR   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_A     = 6'b011010;

  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  localparam logic [1:0] WDSEL_PC  = 2'd0;
  localparam logic [1:0] WDSEL_ALU = 2'd1;
  localparam logic [1:0] WDSEL_MEM = 2'd2;

  typedef enum logic [1:0] {
    ST_EXEC     = 2'd0,
    ST_WAIT_ALU = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_IRQ      = 2'd3   // reserved, never entered
  } state_t;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MUL    = 2'd1,
    CLS_DIV    = 2'd2,
    CLS_MEM    = 2'd3
  } cls_t;

  typedef struct packed {
    logic [5:0] alufn;
    logic [2:0] pcsel;
    logic [1:0] wdsel;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic       ra2sel;
    logic       wasel;
    logic       werf;
  } ctl_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational Beta instruction decoder: opcode and Ra==0 flag to the
// single-cycle control word, a legality flag and an execution class.
// Ports: op/z in; ctl (control word), legal, cls out. No state, no latency.
module ctl_decode
  import ctl_mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic       z,
  output ctl_t       ctl,
  output logic       legal,
  output cls_t       cls
);

  logic [5:0] alu_fn;
  logic       alu_ok;

  always_comb begin
    alu_fn = ALU_ADD;
    alu_ok = 1'b1;
    case (op[3:0])
      4'h0:    alu_fn = ALU_ADD;
      4'h1:    alu_fn = ALU_SUB;
      FN_MUL:  alu_fn = ALU_MUL;
      FN_DIV:  alu_fn = ALU_DIV;
      4'h4:    alu_fn = ALU_CMPEQ;
      4'h5:    alu_fn = ALU_CMPLT;
      4'h6:    alu_fn = ALU_CMPLE;
      4'h8:    alu_fn = ALU_AND;
      4'h9:    alu_fn = ALU_OR;
      4'hA:    alu_fn = ALU_XOR;
      4'hB:    alu_fn = ALU_XNOR;
      4'hC:    alu_fn = ALU_SHL;
      4'hD:    alu_fn = ALU_SHR;
      4'hE:    alu_fn = ALU_SRA;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctl   = '0;
    legal = 1'b1;
    cls   = CLS_SINGLE;
    if (op[5]) begin
      // ALU class; op[4] selects the literal (C) form
      legal     = alu_ok;
      ctl.alufn = alu_fn;
      ctl.bsel  = op[4];
      ctl.wdsel = WDSEL_ALU;
      ctl.werf  = 1'b1;
      if (op[3:0] == FN_MUL)      cls = CLS_MUL;
      else if (op[3:0] == FN_DIV) cls = CLS_DIV;
    end else begin
      case (op)
        OP_LD: begin
          cls       = CLS_MEM;
          ctl.alufn = ALU_ADD;
          ctl.bsel  = 1'b1;
          ctl.moe   = 1'b1;
          ctl.wdsel = WDSEL_MEM;
          ctl.werf  = 1'b1;
        end
        OP_ST: begin
          cls        = CLS_MEM;
          ctl.alufn  = ALU_ADD;
          ctl.bsel   = 1'b1;
          ctl.mwr    = 1'b1;
          ctl.ra2sel = 1'b1;
        end
        OP_LDR: begin
          cls       = CLS_MEM;
          ctl.alufn = ALU_A;
          ctl.asel  = 1'b1;
          ctl.moe   = 1'b1;
          ctl.wdsel = WDSEL_MEM;
          ctl.werf  = 1'b1;
        end
        OP_JMP: begin
          ctl.pcsel = PCSEL_JMP;
          ctl.wdsel = WDSEL_PC;
          ctl.werf  = 1'b1;
        end
        OP_BEQ: begin
          ctl.pcsel = z ? PCSEL_BR : PCSEL_INC;
          ctl.wdsel = WDSEL_PC;
          ctl.werf  = 1'b1;
        end
        OP_BNE: begin
          ctl.pcsel = z ? PCSEL_INC : PCSEL_BR;
          ctl.wdsel = WDSEL_PC;
          ctl.werf  = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ctl_mc.sv
// Multi-cycle Beta control unit: stalls for long MUL/DIV and memory waits,
// traps illegal opcodes and takes prioritised sticky interrupts at
// instruction boundaries. Ports: clk/reset_n, op/z/supervisor/irq/mem_ready
// in; datapath selects, stall, irq_ack/irq_id out (combinational).
module ctl_mc
  import ctl_mc_pkg::*;
#(
  parameter int NIRQ     = 1,
  parameter int MUL_LAT  = 1,
  parameter int DIV_LAT  = 1,
  parameter int MEM_WAIT = 0,
  localparam int IDW     = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      op,
  input  logic            z,
  input  logic            supervisor,
  input  logic [NIRQ-1:0] irq,
  input  logic            mem_ready,
  output logic [5:0]      alufn,
  output logic [2:0]      pcsel,
  output logic [1:0]      wdsel,
  output logic            asel,
  output logic            bsel,
  output logic            moe,
  output logic            mwr,
  output logic            ra2sel,
  output logic            wasel,
  output logic            werf,
  output logic            stall,
  output logic [NIRQ-1:0] irq_ack,
  output logic [IDW-1:0]  irq_id
);

  localparam int MAXLAT = max2(MUL_LAT, DIV_LAT);
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  // Counter preload: entry cycle plus counter+1 wait cycles = LAT total
  localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DIV_LOAD = CW'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NIRQ-1:0] pending;

  ctl_t dec_ctl;
  logic dec_legal;
  cls_t dec_cls;

  ctl_decode u_decode (
    .op    (op),
    .z     (z),
    .ctl   (dec_ctl),
    .legal (dec_legal),
    .cls   (dec_cls)
  );

  logic            mul_mc, div_mc, mem_mc, take_irq;
  logic [NIRQ-1:0] irq_oh;
  logic [IDW-1:0]  irq_idx;
  ctl_t            out;
  logic            stall_c;

  assign mul_mc   = (dec_cls == CLS_MUL) && (MUL_LAT > 1);
  assign div_mc   = (dec_cls == CLS_DIV) && (DIV_LAT > 1);
  assign mem_mc   = (dec_cls == CLS_MEM) && (MEM_WAIT != 0);
  assign take_irq = (pending != '0) && !supervisor;

  // Lowest-index pending channel wins; scan high to low so the last hit sticks
  always_comb begin
    irq_oh  = '0;
    irq_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        irq_oh    = '0;
        irq_oh[i] = 1'b1;
        irq_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    out       = dec_ctl;
    stall_c   = 1'b0;
    irq_ack   = '0;
    irq_id    = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_EXEC: begin
        if (take_irq) begin
          // Interrupt replaces the instruction in IR; it is re-fetched later
          out       = '0;
          out.pcsel = PCSEL_XADR;
          out.wasel = 1'b1;
          out.werf  = 1'b1;
          out.wdsel = WDSEL_PC;
          irq_ack   = irq_oh;
          irq_id    = irq_idx;
        end else if (!dec_legal) begin
          out       = '0;
          out.pcsel = PCSEL_ILLOP;
          out.wasel = 1'b1;
          out.werf  = 1'b1;
          out.wdsel = WDSEL_PC;
        end else if (mul_mc || div_mc) begin
          stall_c   = 1'b1;
          out.werf  = 1'b0;
          cnt_nxt   = mul_mc ? MUL_LOAD : DIV_LOAD;
          state_nxt = ST_WAIT_ALU;
        end else if (mem_mc && !mem_ready) begin
          stall_c   = 1'b1;
          out.werf  = 1'b0;
          state_nxt = ST_WAIT_MEM;
        end
      end
      ST_WAIT_ALU: begin
        // IR is frozen, so the decoded alufn/asel/bsel stay put
        if (cnt != '0) begin
          stall_c  = 1'b1;
          out.werf = 1'b0;
          cnt_nxt  = cnt - CNT_ONE;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_WAIT_MEM: begin
        // moe/mwr held from decode; only the register write waits
        if (!mem_ready) begin
          stall_c  = 1'b1;
          out.werf = 1'b0;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      default: begin
        // Reserved encoding: drive nothing and fall back to EXEC
        out       = '0;
        state_nxt = ST_EXEC;
      end
    endcase

    if (!reset_n) begin
      out     = '0;
      stall_c = 1'b0;
      irq_ack = '0;
      irq_id  = '0;
    end
  end

  assign alufn  = out.alufn;
  assign pcsel  = out.pcsel;
  assign wdsel  = out.wdsel;
  assign asel   = out.asel;
  assign bsel   = out.bsel;
  assign moe    = out.moe;
  assign mwr    = out.mwr;
  assign ra2sel = out.ra2sel;
  assign wasel  = out.wasel;
  assign werf   = out.werf;
  assign stall  = stall_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_EXEC;
      cnt     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // An assertion arriving in the ack cycle re-pends that channel
      pending <= (pending & ~irq_ack) | irq;
    end
  end

endmodule

// File: tb/tb_ctl_mc.sv
// Scoreboard bench for ctl_mc (NIRQ=4, MUL_LAT=3, DIV_LAT=4, MEM_WAIT=1).
// Stimulus drives one instruction cycle at a time and pushes the reference
// model's expected outputs; a monitor on the falling edge pops and compares.
module tb_ctl_mc;

  typedef struct packed {
    logic [5:0] alufn;
    logic [2:0] pcsel;
    logic [1:0] wdsel;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic       ra2sel;
    logic       wasel;
    logic       werf;
    logic       stall;
    logic [3:0] ack;
    logic [1:0] id;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'h20;
  logic       z = 1'b0;
  logic       supervisor = 1'b1;
  logic [3:0] irq = 4'h0;
  logic       mem_ready = 1'b1;

  logic [5:0] alufn;
  logic [2:0] pcsel;
  logic [1:0] wdsel;
  logic       asel, bsel, moe, mwr, ra2sel, wasel, werf, stall;
  logic [3:0] irq_ack;
  logic [1:0] irq_id;

  always #5 clk = ~clk;

  ctl_mc #(.NIRQ(4), .MUL_LAT(3), .DIV_LAT(4), .MEM_WAIT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .z          (z),
    .supervisor (supervisor),
    .irq        (irq),
    .mem_ready  (mem_ready),
    .alufn      (alufn),
    .pcsel      (pcsel),
    .wdsel      (wdsel),
    .asel       (asel),
    .bsel       (bsel),
    .moe        (moe),
    .mwr        (mwr),
    .ra2sel     (ra2sel),
    .wasel      (wasel),
    .werf       (werf),
    .stall      (stall),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id)
  );

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;

  // Reference model state: cycles still owed by a long ALU op, whether a
  // memory access is outstanding, and the sticky interrupt requests.
  int       alu_left = 0;
  bit       mem_busy = 1'b0;
  bit [3:0] pend = 4'h0;
  bit       last_stall = 1'b0;

  // Beta instruction table, written out opcode by opcode
  function automatic obs_t beta(input logic [5:0] o, input logic zz, output bit legal);
    obs_t e;
    e = '0;
    legal = 1'b1;
    case (o)
      6'h18: begin e.alufn = 6'h00; e.bsel = 1; e.moe = 1; e.wdsel = 2; e.werf = 1; end
      6'h19: begin e.alufn = 6'h00; e.bsel = 1; e.mwr = 1; e.ra2sel = 1; end
      6'h1F: begin e.alufn = 6'h1A; e.asel = 1; e.moe = 1; e.wdsel = 2; e.werf = 1; end
      6'h1B: begin e.pcsel = 2; e.werf = 1; end
      6'h1C: begin e.pcsel = zz ? 3'd1 : 3'd0; e.werf = 1; end
      6'h1D: begin e.pcsel = zz ? 3'd0 : 3'd1; e.werf = 1; end
      6'h20, 6'h30: e.alufn = 6'h00;
      6'h21, 6'h31: e.alufn = 6'h01;
      6'h22, 6'h32: e.alufn = 6'h02;
      6'h23, 6'h33: e.alufn = 6'h03;
      6'h24, 6'h34: e.alufn = 6'h33;
      6'h25, 6'h35: e.alufn = 6'h35;
      6'h26, 6'h36: e.alufn = 6'h37;
      6'h28, 6'h38: e.alufn = 6'h18;
      6'h29, 6'h39: e.alufn = 6'h1E;
      6'h2A, 6'h3A: e.alufn = 6'h16;
      6'h2B, 6'h3B: e.alufn = 6'h19;
      6'h2C, 6'h3C: e.alufn = 6'h20;
      6'h2D, 6'h3D: e.alufn = 6'h21;
      6'h2E, 6'h3E: e.alufn = 6'h23;
      default: legal = 1'b0;
    endcase
    if (legal && o >= 6'h20) begin
      e.wdsel = 1;
      e.werf  = 1;
      e.bsel  = (o >= 6'h30);
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model
  task automatic cyc(input logic r, input logic [5:0] o, input logic zz,
                     input logic s, input logic [3:0] q, input logic m);
    obs_t e;
    bit   lg;
    int   lat;
    bit   found;
    @(posedge clk);
    #1;
    reset_n = r; op = o; z = zz; supervisor = s; irq = q; mem_ready = m;
    e = '0;
    if (!r) begin
      pend = 4'h0; alu_left = 0; mem_busy = 1'b0;
    end else begin
      e = beta(o, zz, lg);
      if (alu_left == 0 && !mem_busy) begin
        if (pend != 4'h0 && !s) begin
          e = '0; e.pcsel = 4; e.wasel = 1; e.werf = 1;
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (pend[k] && !found) begin
              found = 1'b1; e.ack[k] = 1'b1; e.id = 2'(k);
            end
          end
        end else if (!lg) begin
          e = '0; e.pcsel = 3; e.wasel = 1; e.werf = 1;
        end else begin
          lat = (o == 6'h22 || o == 6'h32) ? 3 : (o == 6'h23 || o == 6'h33) ? 4 : 1;
          if (lat > 1) begin
            e.stall = 1; e.werf = 0; alu_left = lat - 1;
          end else if ((o == 6'h18 || o == 6'h19 || o == 6'h1F) && !m) begin
            e.stall = 1; e.werf = 0; mem_busy = 1'b1;
          end
        end
      end else if (alu_left > 0) begin
        alu_left--;
        if (alu_left > 0) begin e.stall = 1; e.werf = 0; end
      end else begin
        if (!m) begin e.stall = 1; e.werf = 0; end
        else mem_busy = 1'b0;
      end
      pend = (pend & ~e.ack) | q;
    end
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  // Monitor: compares whatever the DUT shows mid-cycle against the queue head
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {alufn, pcsel, wdsel, asel, bsel, moe, mwr, ra2sel, wasel, werf,
             stall, irq_ack, irq_id};
        if (e.ack == 4'h0) a.id = 2'b00;  // irq_id only meaningful with an ack
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d op=%h: got alufn=%h pcsel=%0d wdsel=%0d sel/en=%b stall=%b ack=%b id=%0d, expected alufn=%h pcsel=%0d wdsel=%0d sel/en=%b stall=%b ack=%b id=%0d",
                   cycle_no, op, a.alufn, a.pcsel, a.wdsel,
                   {a.asel, a.bsel, a.moe, a.mwr, a.ra2sel, a.wasel, a.werf}, a.stall, a.ack, a.id,
                   e.alufn, e.pcsel, e.wdsel,
                   {e.asel, e.bsel, e.moe, e.mwr, e.ra2sel, e.wasel, e.werf}, e.stall, e.ack, e.id);
        end
        cycle_no++;
      end
    end
  end

  initial begin
    logic [5:0] legal_ops [0:11];
    logic [5:0] ro;
    legal_ops = '{6'h18, 6'h19, 6'h1F, 6'h1B, 6'h1C, 6'h1D,
                  6'h22, 6'h32, 6'h23, 6'h33, 6'h20, 6'h3C};

    // Reset with a live interrupt, then release and let it be taken
    cyc(0, 6'h20, 0, 0, 4'h1, 1);
    cyc(0, 6'h20, 0, 0, 4'h1, 1);
    cyc(1, 6'h20, 0, 0, 4'h1, 1);
    cyc(1, 6'h20, 0, 0, 4'h0, 1);
    cyc(1, 6'h20, 0, 0, 4'h0, 1);
    // DIVC: four cycles, one write at the end
    repeat (4) cyc(1, 6'h33, 0, 1, 4'h0, 1);
    cyc(1, 6'h21, 0, 1, 4'h0, 1);
    // ST with memory wait of three cycles
    repeat (3) cyc(1, 6'h19, 0, 1, 4'h0, 0);
    cyc(1, 6'h19, 0, 1, 4'h0, 1);
    // LD and LDR with a wait, LD completing immediately
    repeat (2) cyc(1, 6'h18, 0, 1, 4'h0, 0);
    cyc(1, 6'h18, 0, 1, 4'h0, 1);
    cyc(1, 6'h1F, 0, 1, 4'h0, 0);
    cyc(1, 6'h1F, 0, 1, 4'h0, 1);
    cyc(1, 6'h18, 0, 1, 4'h0, 1);
    // Two-channel pulse held off by supervisor, then taken in priority order
    cyc(1, 6'h20, 0, 1, 4'b1010, 1);
    repeat (2) cyc(1, 6'h24, 0, 1, 4'h0, 1);
    repeat (3) cyc(1, 6'h24, 0, 0, 4'h0, 1);
    // Illegal opcode in supervisor mode, then pending irq overrides it
    cyc(1, 6'h00, 0, 1, 4'h0, 1);
    cyc(1, 6'h27, 0, 1, 4'b0100, 1);
    cyc(1, 6'h00, 0, 0, 4'h0, 1);
    cyc(1, 6'h00, 0, 0, 4'h0, 1);
    // MUL aborted by reset in its second cycle
    cyc(1, 6'h22, 0, 1, 4'h0, 1);
    cyc(0, 6'h22, 0, 1, 4'h0, 1);
    cyc(1, 6'h20, 0, 1, 4'h0, 1);
    // Full-length MULC, then an irq arriving mid-stall is deferred
    cyc(1, 6'h32, 0, 0, 4'h8, 1);
    cyc(1, 6'h32, 0, 0, 4'h0, 1);
    cyc(1, 6'h32, 0, 0, 4'h0, 1);
    cyc(1, 6'h20, 0, 0, 4'h0, 1);
    // Branches and JMP on both z values
    cyc(1, 6'h1C, 1, 1, 4'h0, 1);
    cyc(1, 6'h1D, 1, 1, 4'h0, 1);
    cyc(1, 6'h1C, 0, 1, 4'h0, 1);
    cyc(1, 6'h1D, 0, 1, 4'h0, 1);
    cyc(1, 6'h1B, 1, 1, 4'h0, 1);

    // Random traffic; the opcode is held whenever the model predicts a stall
    ro = 6'h20;
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall)
        ro = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 11)]
                                         : 6'($urandom_range(0, 63));
      cyc(($urandom_range(0, 99) != 0), ro, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
          ($urandom_range(0, 9) < 6));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
